// File: rtl/instr_encoder_loader.sv
// Encodes symbolic MIPS instruction requests into machine words and streams them into instruction memory.
// Optional running XOR checksum of written words is enabled by defining INSTR_ENC_CKSUM_EN.
module instr_encoder_loader #(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        finish,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_op,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [25:0] in_imm,
    output logic        im_we,
    output logic [31:0] im_addr,
    output logic [31:0] im_wdata,
    output logic [10:0] count,
    output logic        busy,
    output logic        full,
    output logic        err,
    output logic [31:0] cksum
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FULL
    } state_t;

    localparam logic [10:0] DEPTH_W = 11'(DEPTH);

    state_t      state;
    logic        accept;
    logic        legal;
    logic [31:0] enc;
    logic [15:0] imm16;

    assign in_ready = (state == RUN) && (count < DEPTH_W);
    assign accept   = in_valid && in_ready;
    assign imm16    = in_imm[15:0];

    // Fields not used by an op are left at zero by construction of each word.
    always_comb begin
        enc   = '0;
        legal = 1'b1;
        case (in_op)
            4'd0:    enc = '0;
            4'd1:    enc = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100000};
            4'd2:    enc = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100010};
            4'd3:    enc = {6'b001101, in_rs, in_rt, imm16};
            4'd4:    enc = {6'b100011, in_rs, in_rt, imm16};
            4'd5:    enc = {6'b101011, in_rs, in_rt, imm16};
            4'd6:    enc = {6'b001111, 5'b00000, in_rt, imm16};
            4'd7:    enc = {6'b000100, in_rs, in_rt, imm16};
            4'd8:    enc = {6'b000010, in_imm};
            4'd9:    enc = {6'b000011, in_imm};
            4'd10:   enc = {6'b000000, in_rs, 15'd0, 6'b001000};
            default: legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            im_we    <= 1'b0;
            im_addr  <= BASE_ADDR;
            im_wdata <= '0;
            count    <= '0;
            busy     <= 1'b0;
            full     <= 1'b0;
            err      <= 1'b0;
        end else begin
            im_we <= accept && legal;
            if (accept && legal) begin
                im_addr  <= BASE_ADDR + {19'd0, count, 2'b00};
                im_wdata <= enc;
                count    <= count + 11'd1;
            end
            if (accept && !legal) begin
                err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        count <= '0;
                        err   <= 1'b0;
                    end
                end
                RUN: begin
                    // finish wins over filling; a coincident acceptance still writes.
                    if (finish) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (accept && legal && (count + 11'd1 == DEPTH_W)) begin
                        state <= FULL;
                        busy  <= 1'b0;
                        full  <= 1'b1;
                    end
                end
                FULL: begin
                    if (finish) begin
                        state <= IDLE;
                        full  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    full  <= 1'b0;
                end
            endcase
        end
    end

`ifdef INSTR_ENC_CKSUM_EN
    // A new session clears the sum even if the previous session's last write is on the bus.
    always_ff @(posedge clk) begin
        if (reset || (state == IDLE && start)) begin
            cksum <= '0;
        end else if (im_we) begin
            cksum <= cksum ^ im_wdata;
        end
    end
`else
    assign cksum = '0;
`endif

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for instr_encoder_loader: directed test-plan vectors followed by randomized sessions.
module tb_instr_encoder_loader;

    localparam int unsigned DEPTH = 8;
    localparam logic [31:0] BASE  = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        reset, start, finish, in_valid, in_ready;
    logic [3:0]  in_op;
    logic [4:0]  in_rs, in_rt, in_rd;
    logic [25:0] in_imm;
    logic        im_we;
    logic [31:0] im_addr, im_wdata, cksum;
    logic [10:0] count;
    logic        busy, full, err;

    instr_encoder_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
        .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .count(count), .busy(busy), .full(full), .err(err), .cksum(cksum)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          mon_on = 0;

    // Reference model state
    bit          m_sess;
    int          m_cnt;
    bit          m_err;
    logic [31:0] m_ck, m_pend, cur_exp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [3:0] op, input logic [4:0] rs,
                                             input logic [4:0] rt, input logic [4:0] rd,
                                             input logic [25:0] imm);
        logic [15:0] i16;
        i16 = imm[15:0];
        case (op)
            4'd1:    return {6'h00, rs, rt, rd, 5'd0, 6'h20};
            4'd2:    return {6'h00, rs, rt, rd, 5'd0, 6'h22};
            4'd3:    return {6'h0D, rs, rt, i16};
            4'd4:    return {6'h23, rs, rt, i16};
            4'd5:    return {6'h2B, rs, rt, i16};
            4'd6:    return {6'h0F, 5'd0, rt, i16};
            4'd7:    return {6'h04, rs, rt, i16};
            4'd8:    return {6'h02, imm};
            4'd9:    return {6'h03, imm};
            4'd10:   return {6'h00, rs, 21'd8};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] exp_ck();
`ifdef INSTR_ENC_CKSUM_EN
        return m_ck;
`else
        return 32'h0;
`endif
    endfunction

    // Monitor: every write must match the oldest expected write, one cycle after acceptance.
    always @(negedge clk) begin
        if (mon_on) begin
            chk("im_we", {31'd0, im_we}, {31'd0, q.size() != 0});
            if (im_we === 1'b1 && q.size() != 0) begin
                wr_t w;
                w = q.pop_front();
                chk("im_addr", im_addr, w.addr);
                chk("im_wdata", im_wdata, w.data);
            end
        end
    end

    task automatic model_edge();
        if (reset) begin
            m_sess = 0; m_cnt = 0; m_err = 0; m_ck = '0; m_pend = '0;
        end else begin
            if (!m_sess && start) m_ck = '0;
            else m_ck = m_ck ^ m_pend;
            m_pend = '0;
            if (!m_sess) begin
                if (start) begin
                    m_sess = 1; m_cnt = 0; m_err = 0;
                end
            end else begin
                if (in_valid && m_cnt < int'(DEPTH)) begin
                    if (in_op > 4'd10) begin
                        m_err = 1;
                    end else begin
                        q.push_back('{addr: BASE + 32'(4 * m_cnt), data: cur_exp});
                        m_pend = cur_exp;
                        m_cnt++;
                    end
                end
                if (finish) m_sess = 0;
            end
        end
    endtask

    // Called at a negedge with inputs driven: check outputs, clock once, return at next negedge.
    task automatic tick();
        chk("in_ready", {31'd0, in_ready}, {31'd0, m_sess && m_cnt < int'(DEPTH)});
        chk("count", {21'd0, count}, 32'(m_cnt));
        chk("busy", {31'd0, busy}, {31'd0, m_sess && m_cnt < int'(DEPTH)});
        chk("full", {31'd0, full}, {31'd0, m_sess && m_cnt == int'(DEPTH)});
        chk("err", {31'd0, err}, {31'd0, m_err});
        chk("cksum", cksum, exp_ck());
        @(posedge clk);
        model_edge();
        @(negedge clk);
        reset = 0; start = 0; finish = 0; in_valid = 0;
    endtask

    task automatic send(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [25:0] imm, input logic [31:0] word);
        in_valid = 1; in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm;
        cur_exp = word;
        tick();
    endtask

    task automatic check_reset_outputs();
        chk("rst_im_we", {31'd0, im_we}, 32'd0);
        chk("rst_im_addr", im_addr, BASE);
        chk("rst_im_wdata", im_wdata, 32'd0);
        chk("rst_cksum", cksum, 32'd0);
        chk("rst_count", {21'd0, count}, 32'd0);
    endtask

    initial begin
        reset = 1; start = 0; finish = 0; in_valid = 0;
        in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0; cur_exp = '0;
        m_sess = 0; m_cnt = 0; m_err = 0; m_ck = '0; m_pend = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 0;
        mon_on = 1;
        check_reset_outputs();

        // Session 1: test-plan vectors, illegal op, fill to DEPTH
        start = 1; tick();
        send(4'd1, 5'd1, 5'd2, 5'd3, 26'h0, 32'h00221820);
        tick();
        send(4'd3, 5'd0, 5'd1, 5'd9, 26'h3FF1234, 32'h34011234);
        send(4'd6, 5'd7, 5'd8, 5'd9, 26'h000FFFF, 32'h3C08FFFF);
        send(4'd5, 5'd0, 5'd4, 5'd9, 26'h0000008, 32'hAC040008);
        send(4'd9, 5'd3, 5'd3, 5'd3, 26'h0000C03, 32'h0C000C03);
        send(4'd10, 5'd31, 5'd5, 5'd6, 26'h3FFFFFF, 32'h03E00008);
        send(4'd12, 5'd1, 5'd1, 5'd1, 26'h1, 32'h0);
        chk("err_after_illegal", {31'd0, err}, 32'd1);
        send(4'd7, 5'd1, 5'd2, 5'd0, 26'h000FFFF, 32'h1022FFFF);
        send(4'd0, 5'd9, 5'd9, 5'd9, 26'h1234, 32'h0);
        chk("full_at_depth", {31'd0, full}, 32'd1);
        chk("ready_at_depth", {31'd0, in_ready}, 32'd0);
        send(4'd1, 5'd1, 5'd1, 5'd1, 26'h0, 32'h00210820);
        start = 1; tick();
        finish = 1; tick();
        tick();

        // Session 2: restart addresses, checksum vector, reset with a request pending
        start = 1; tick();
        chk("count_restart", {21'd0, count}, 32'd0);
        send(4'd1, 5'd1, 5'd2, 5'd3, 26'h0, 32'h00221820);
        send(4'd3, 5'd0, 5'd1, 5'd0, 26'h0001234, 32'h34011234);
        tick();
`ifdef INSTR_ENC_CKSUM_EN
        chk("cksum_plan", cksum, 32'h34230A14);
`endif
        reset = 1;
        send(4'd2, 5'd4, 5'd5, 5'd6, 26'h0, 32'h00853022);
        check_reset_outputs();
        tick();

        // Randomized sessions
        for (int i = 0; i < 600; i++) begin
            int r;
            r = $urandom_range(0, 199);
            start  = (r < 6) || (!m_sess && $urandom_range(0, 3) == 0);
            finish = (r >= 6 && r < 14);
            reset  = (r == 199);
            in_valid = ($urandom_range(0, 3) != 0);
            in_op  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(11, 15)) : 4'($urandom_range(0, 10));
            in_rs  = 5'($urandom);
            in_rt  = 5'($urandom);
            in_rd  = 5'($urandom);
            in_imm = 26'($urandom);
            cur_exp = ref_word(in_op, in_rs, in_rt, in_rd, in_imm);
            tick();
        end

        tick();
        tick();
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Hardware instruction encoder and loader for the single-cycle MIPS core.
- Accepts symbolic instruction requests (op class, rs, rt, rd, immediate) over a valid/ready handshake and encodes each into a 32-bit MIPS machine word.
- Writes the words sequentially into instruction memory starting at a base address.
- Covers the same instruction set the core's decoder handles: nop, add, sub, ori, lw, sw, lui, beq, j, jal, jr.

Parameters:
- DEPTH, 1024, maximum number of words loaded per session.
- BASE_ADDR, 32'h0000_3000, byte address of the first word written.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; opens a load session.
- finish  input  1  one-cycle pulse; closes the session.
- in_valid  input  1  request valid.
- in_ready  output  1  request accepted this cycle when in_valid & in_ready.
- in_op  input  4  0 NOP, 1 ADD, 2 SUB, 3 ORI, 4 LW, 5 SW, 6 LUI, 7 BEQ, 8 J, 9 JAL, 10 JR; 11-15 illegal.
- in_rs, in_rt, in_rd  input  5 each  register fields.
- in_imm  input  26  low 16 bits are imm16; all 26 bits are the j/jal target.
- im_we  output  1  instruction-memory write strobe.
- im_addr  output  32  byte address of the write.
- im_wdata  output  32  encoded word.
- count  output  11  legal words accepted this session.
- busy  output  1  high in RUN.
- full  output  1  high in FULL.
- err  output  1  sticky illegal-op flag.
- cksum  output  32  see Optional Feature.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; in_ready, im_we, busy, full, err = 0; im_addr = BASE_ADDR; im_wdata = 0; count = 0; cksum = 0. Reset mid-session aborts the session; any pending write is dropped.
- States:
  - IDLE: start moves to RUN, clears count, err and cksum.
  - RUN: accepts requests. Moves to FULL on the acceptance that makes count==DEPTH. finish moves to IDLE.
  - FULL: in_ready=0. finish moves to IDLE. start is ignored in RUN and FULL.
- in_ready = (state==RUN) && (count<DEPTH). It is combinational from registered state and count.
- Latency: a legal request accepted in cycle N produces im_we=1 in cycle N+1, with im_addr = BASE_ADDR + 4*count_at_accept and im_wdata = the encoded word. count increments at the end of cycle N.
- Throughput: one word per cycle. im_we is high only in cycles following an acceptance.
- Illegal op accepted: no write, count unchanged, err set and held until the next start or reset.
- finish in the same cycle as an acceptance: the request is accepted and its write still issues in N+1; state goes to IDLE.
- Encoding (op,rs,rt,rd,shamt,funct / imm16 / target26):
  - NOP: 32'h0.
  - ADD: 000000,rs,rt,rd,00000,100000.
  - SUB: funct 100010.
  - JR: 000000,rs,0,0,0,001000.
  - ORI: 001101,rs,rt,imm16.
  - LW: 100011,rs,rt,imm16.
  - SW: 101011,rs,rt,imm16.
  - LUI: 001111,00000,rt,imm16 (in_rs ignored).
  - BEQ: 000100,rs,rt,imm16.
  - J: 000010,target26.
  - JAL: 000011,target26.
  - Fields unused by an op are forced to zero regardless of input.
- im_addr uses 32-bit unsigned arithmetic. DEPTH guarantees no wrap within a session.

Optional Feature:
- Macro: INSTR_ENC_CKSUM_EN.
- Defined: cksum is the running XOR of every im_wdata written this session. It updates in the same cycle as im_we (registered value visible the next cycle) and clears on start or reset.
- Undefined: cksum is constant 0 and no checksum register exists.

Test Plan:
- reset, start, ADD rs=1 rt=2 rd=3 -> next cycle im_we=1, im_addr=32'h3000, im_wdata=32'h00221820; count=1.
- Back-to-back ORI rs=0 rt=1 imm=0x1234, LUI rs=7 rt=8 imm=0xFFFF, SW rs=0 rt=4 imm=8 -> writes at 0x3000, 0x3004, 0x3008 with words 32'h34011234, 32'h3C08FFFF, 32'hAC040008 on consecutive cycles.
- JAL imm=26'h0000C03, JR rs=31, BEQ rs=1 rt=2 imm=0xFFFF -> 32'h0C000C03, 32'h03E00008, 32'h1022FFFF.
- in_op=12 mid-stream -> no im_we, count unchanged, err=1 until the next start; the following legal op is written at the next sequential address.
- DEPTH=4, five valid requests -> four writes (0x3000-0x300C), full=1, in_ready=0; finish -> IDLE; start -> count=0, addresses restart at 0x3000.
- With INSTR_ENC_CKSUM_EN, writes 32'h00221820 and 32'h34011234 -> cksum=32'h34230A14; reset asserted mid-session -> all outputs at reset values the next cycle.
